// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: controller states, bus encodings,
// instruction fields and the packed control bundle driven by the controller.
package cpu_pkg;

    localparam int unsigned STATE_W = 5;
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned MEM_W   = 2;
    localparam int unsigned NSEL_W  = 3;
    localparam int unsigned VSEL_W  = 2;

    // ALU is split by flavour so every output stays a pure function of state
    typedef enum logic [STATE_W-1:0] {
        RST,
        IF1,
        IF2,
        UPDATE_PC,
        DECODE,
        WRITE_IMM,
        GET_A,
        GET_B,
        ALU,
        ALU_ASEL,
        ALU_CMP,
        WRITE_RD,
        ADDR_CALC,
        LOAD_ADDR,
        MEM_RD1,
        MEM_RD2,
        GET_D,
        PASS_D,
        MEM_WR,
        HALT,
        HALT_ILL
    } state_e;

    localparam logic [MEM_W-1:0] MEM_NONE  = 2'b00;
    localparam logic [MEM_W-1:0] MEM_READ  = 2'b01;
    localparam logic [MEM_W-1:0] MEM_WRITE = 2'b10;

    localparam logic [VSEL_W-1:0] VSEL_C     = 2'd0;
    localparam logic [VSEL_W-1:0] VSEL_PC    = 2'd1;
    localparam logic [VSEL_W-1:0] VSEL_IMM   = 2'd2;
    localparam logic [VSEL_W-1:0] VSEL_MDATA = 2'd3;

    localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
    localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b001;
    localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
    localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b100;

    localparam logic [OPC_W-1:0] OPC_LDR  = 3'b011;
    localparam logic [OPC_W-1:0] OPC_STR  = 3'b100;
    localparam logic [OPC_W-1:0] OPC_ALU  = 3'b101;
    localparam logic [OPC_W-1:0] OPC_MOV  = 3'b110;
    localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

    localparam logic [OP_W-1:0] OP_MOV_REG = 2'b00;
    localparam logic [OP_W-1:0] OP_MOV_IMM = 2'b10;
    localparam logic [OP_W-1:0] OP_ADD     = 2'b00;
    localparam logic [OP_W-1:0] OP_CMP     = 2'b01;
    localparam logic [OP_W-1:0] OP_AND     = 2'b10;
    localparam logic [OP_W-1:0] OP_MVN     = 2'b11;
    localparam logic [OP_W-1:0] OP_MEM     = 2'b00;

    typedef struct packed {
        logic              load_ir;
        logic              load_pc;
        logic              reset_pc;
        logic              addr_sel;
        logic              load_addr;
        logic [MEM_W-1:0]  mem_cmd;
        logic [NSEL_W-1:0] nsel;
        logic [VSEL_W-1:0] vsel;
        logic              write;
        logic              loada;
        logic              loadb;
        logic              loadc;
        logic              loads;
        logic              asel;
        logic              bsel;
        logic              halted;
        logic              illegal;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LDR) || (opc == OPC_STR);
    endfunction

    // ALU flavour once both operands are (or need not be) loaded
    function automatic state_e alu_state(input logic [OPC_W-1:0] opc,
                                         input logic [OP_W-1:0]  op);
        if (opc == OPC_MOV || (opc == OPC_ALU && op == OP_MVN))
            return ALU_ASEL;
        if (opc == OPC_ALU && op == OP_CMP)
            return ALU_CMP;
        return ALU;
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Instruction fields in, datapath/memory control out, between controller and datapath.
interface cpu_ctrl_fsm_if;

    logic [2:0] opcode;
    logic [1:0] op;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       addr_sel;
    logic       load_addr;
    logic [1:0] mem_cmd;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       halted;
    logic       illegal;

    modport master (
        input  opcode, op,
        output load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd,
               nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               halted, illegal
    );

    modport slave (
        output opcode, op,
        input  load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd,
               nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               halted, illegal
    );

endinterface

// File: rtl/cpu_ctrl_outdec.sv
// Moore output decode: control bundle as a pure function of controller state.
// CPU_CTRL_ILLEGAL_TRAP_EN enables the illegal-instruction trap state's flag.
module cpu_ctrl_outdec
    import cpu_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            RST: begin
                ctrl.reset_pc = 1'b1;
                ctrl.load_pc  = 1'b1;
            end
            IF1: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_cmd  = MEM_READ;
            end
            IF2: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_cmd  = MEM_READ;
                ctrl.load_ir  = 1'b1;
            end
            UPDATE_PC: ctrl.load_pc = 1'b1;
            WRITE_IMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM;
                ctrl.write = 1'b1;
            end
            GET_A: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            GET_B: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            ALU:      ctrl.loadc = 1'b1;
            ALU_ASEL: begin
                ctrl.loadc = 1'b1;
                ctrl.asel  = 1'b1;
            end
            ALU_CMP:  ctrl.loads = 1'b1;
            WRITE_RD: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_C;
                ctrl.write = 1'b1;
            end
            ADDR_CALC: begin
                ctrl.bsel  = 1'b1;
                ctrl.loadc = 1'b1;
            end
            LOAD_ADDR: ctrl.load_addr = 1'b1;
            MEM_RD1: begin
                ctrl.addr_sel = 1'b0;
                ctrl.mem_cmd  = MEM_READ;
            end
            MEM_RD2: begin
                ctrl.addr_sel = 1'b0;
                ctrl.mem_cmd  = MEM_READ;
                ctrl.nsel     = NSEL_RD;
                ctrl.vsel     = VSEL_MDATA;
                ctrl.write    = 1'b1;
            end
            GET_D: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.loadb = 1'b1;
            end
            PASS_D: begin
                ctrl.asel  = 1'b1;
                ctrl.loadc = 1'b1;
            end
            MEM_WR: begin
                ctrl.addr_sel = 1'b0;
                ctrl.mem_cmd  = MEM_WRITE;
            end
            HALT: ctrl.halted = 1'b1;
            HALT_ILL: begin
                ctrl.halted = 1'b1;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                ctrl.illegal = 1'b1;
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU controller: state register and next-state logic, outputs registered
// from the decode of the next state. CPU_CTRL_ILLEGAL_TRAP_EN traps unlisted instructions.
module cpu_ctrl_fsm
    import cpu_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    cpu_ctrl_fsm_if.master bus
);

    state_e state;
    state_e state_d;
    state_e dec_state;
    ctrl_t  ctrl_d;
    ctrl_t  ctrl_q;

    // Next-state transition table
    always_comb begin
        state_d = state;
        case (state)
            RST:       state_d = IF1;
            IF1:       state_d = IF2;
            IF2:       state_d = UPDATE_PC;
            UPDATE_PC: state_d = DECODE;
            DECODE: begin
                if (bus.opcode == OPC_HALT) begin
                    state_d = HALT;
                end else begin
                    case ({bus.opcode, bus.op})
                        {OPC_MOV, OP_MOV_IMM}: state_d = WRITE_IMM;
                        {OPC_MOV, OP_MOV_REG}: state_d = GET_B;
                        {OPC_ALU, OP_ADD},
                        {OPC_ALU, OP_CMP},
                        {OPC_ALU, OP_AND}:     state_d = GET_A;
                        {OPC_ALU, OP_MVN}:     state_d = GET_B;
                        {OPC_LDR, OP_MEM},
                        {OPC_STR, OP_MEM}:     state_d = GET_A;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                        default:               state_d = HALT_ILL;
`else
                        default:               state_d = IF1;
`endif
                    endcase
                end
            end
            WRITE_IMM: state_d = IF1;
            GET_A:     state_d = is_mem_op(bus.opcode) ? ADDR_CALC : GET_B;
            GET_B:     state_d = alu_state(bus.opcode, bus.op);
            ALU:       state_d = WRITE_RD;
            ALU_ASEL:  state_d = WRITE_RD;
            ALU_CMP:   state_d = IF1;
            WRITE_RD:  state_d = IF1;
            ADDR_CALC: state_d = LOAD_ADDR;
            LOAD_ADDR: state_d = (bus.opcode == OPC_LDR) ? MEM_RD1 : GET_D;
            MEM_RD1:   state_d = MEM_RD2;
            MEM_RD2:   state_d = IF1;
            GET_D:     state_d = PASS_D;
            PASS_D:    state_d = MEM_WR;
            MEM_WR:    state_d = IF1;
            HALT:      state_d = HALT;
            HALT_ILL:  state_d = HALT_ILL;
            default:   state_d = RST;
        endcase
    end

    // Decoding the state about to be entered lets the outputs come straight off flops
    always_comb begin
        dec_state = state_d;
        if (reset)
            dec_state = RST;
    end

    cpu_ctrl_outdec u_outdec (
        .state (dec_state),
        .ctrl  (ctrl_d)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= RST;
        else
            state <= state_d;
        ctrl_q <= ctrl_d;
    end

    assign bus.load_ir   = ctrl_q.load_ir;
    assign bus.load_pc   = ctrl_q.load_pc;
    assign bus.reset_pc  = ctrl_q.reset_pc;
    assign bus.addr_sel  = ctrl_q.addr_sel;
    assign bus.load_addr = ctrl_q.load_addr;
    assign bus.mem_cmd   = ctrl_q.mem_cmd;
    assign bus.nsel      = ctrl_q.nsel;
    assign bus.vsel      = ctrl_q.vsel;
    assign bus.write     = ctrl_q.write;
    assign bus.loada     = ctrl_q.loada;
    assign bus.loadb     = ctrl_q.loadb;
    assign bus.loadc     = ctrl_q.loadc;
    assign bus.loads     = ctrl_q.loads;
    assign bus.asel      = ctrl_q.asel;
    assign bus.bsel      = ctrl_q.bsel;
    assign bus.halted    = ctrl_q.halted;
    assign bus.illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: expected per-cycle control bundles are queued
// per instruction and compared each cycle on the falling edge.
module tb_cpu_ctrl_fsm;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_ctrl_fsm_if bus ();

    cpu_ctrl_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef enum int {
        T_RST, T_IF1, T_IF2, T_UPD, T_DEC, T_WIMM, T_GETA, T_GETB, T_ALU,
        T_ALUA, T_ALUC, T_WRD, T_ACALC, T_LADDR, T_RD1, T_RD2, T_GETD,
        T_PASSD, T_MWR, T_HALT, T_TRAP
    } tst_e;

    int    n_tests = 0;
    int    n_fail  = 0;
    tst_e  exp_q[$];
    string tag;
    int    cnt_write, cnt_memwr, cnt_loads, cnt_loadc, cnt_halt;

    // Expected control values for each controller step, written from the state table
    function automatic ctrl_t ref_ctrl(input tst_e s);
        ctrl_t c;
        c = '0;
        case (s)
            T_RST:   begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            T_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; end
            T_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = 2'b01; c.load_ir = 1'b1; end
            T_UPD:   c.load_pc = 1'b1;
            T_DEC:   ;
            T_WIMM:  begin c.nsel = 3'b100; c.vsel = 2'd2; c.write = 1'b1; end
            T_GETA:  begin c.nsel = 3'b100; c.loada = 1'b1; end
            T_GETB:  begin c.nsel = 3'b001; c.loadb = 1'b1; end
            T_ALU:   c.loadc = 1'b1;
            T_ALUA:  begin c.loadc = 1'b1; c.asel = 1'b1; end
            T_ALUC:  c.loads = 1'b1;
            T_WRD:   begin c.nsel = 3'b010; c.vsel = 2'd0; c.write = 1'b1; end
            T_ACALC: begin c.bsel = 1'b1; c.loadc = 1'b1; end
            T_LADDR: c.load_addr = 1'b1;
            T_RD1:   c.mem_cmd = 2'b01;
            T_RD2:   begin c.mem_cmd = 2'b01; c.nsel = 3'b010; c.vsel = 2'd3; c.write = 1'b1; end
            T_GETD:  begin c.nsel = 3'b010; c.loadb = 1'b1; end
            T_PASSD: begin c.asel = 1'b1; c.loadc = 1'b1; end
            T_MWR:   c.mem_cmd = 2'b10;
            T_HALT:  c.halted = 1'b1;
            T_TRAP:  begin c.halted = 1'b1; c.illegal = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // One clock, then pop the next expectation and compare against the pins
    task automatic step();
        ctrl_t obs, expv;
        tst_e  s;
        @(posedge clk);
        @(negedge clk);
        obs = {bus.load_ir, bus.load_pc, bus.reset_pc, bus.addr_sel, bus.load_addr,
               bus.mem_cmd, bus.nsel, bus.vsel, bus.write, bus.loada, bus.loadb,
               bus.loadc, bus.loads, bus.asel, bus.bsel, bus.halted, bus.illegal};
        if (obs.write)             cnt_write++;
        if (obs.mem_cmd == 2'b10)  cnt_memwr++;
        if (obs.loads)             cnt_loads++;
        if (obs.loadc)             cnt_loadc++;
        if (obs.halted && obs.mem_cmd == 2'b00) cnt_halt++;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            s    = exp_q.pop_front();
            expv = ref_ctrl(s);
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL %s: step %s got %h want %h", tag, s.name(), obs, expv);
            end
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) step();
    endtask

    task automatic start_instr(input string name, input logic [2:0] opc, input logic [1:0] opv);
        tag        = name;
        reset      = 1'b0;
        bus.opcode = opc;
        bus.op     = opv;
        cnt_write  = 0;
        cnt_memwr  = 0;
        cnt_loads  = 0;
        cnt_loadc  = 0;
        cnt_halt   = 0;
        exp_q.push_back(T_IF1);
        exp_q.push_back(T_IF2);
        exp_q.push_back(T_UPD);
        exp_q.push_back(T_DEC);
    endtask

    task automatic test_reset();
        tag        = "reset";
        reset      = 1'b1;
        bus.opcode = 3'b000;
        bus.op     = 2'b00;
        exp_q.push_back(T_RST);
        exp_q.push_back(T_RST);
        drain();
    endtask

    task automatic test_mov_imm();
        start_instr("mov_imm", 3'b110, 2'b10);
        exp_q.push_back(T_WIMM);
        drain();
    endtask

    task automatic test_ldr();
        start_instr("ldr", 3'b011, 2'b00);
        exp_q.push_back(T_GETA);
        exp_q.push_back(T_ACALC);
        exp_q.push_back(T_LADDR);
        exp_q.push_back(T_RD1);
        exp_q.push_back(T_RD2);
        drain();
        n_tests++;
        if (cnt_write !== 1) begin
            n_fail++;
            $display("FAIL ldr_write_count: got %0d want 1", cnt_write);
        end
    endtask

    task automatic test_str();
        start_instr("str", 3'b100, 2'b00);
        exp_q.push_back(T_GETA);
        exp_q.push_back(T_ACALC);
        exp_q.push_back(T_LADDR);
        exp_q.push_back(T_GETD);
        exp_q.push_back(T_PASSD);
        exp_q.push_back(T_MWR);
        drain();
        n_tests++;
        if (cnt_memwr !== 1 || cnt_write !== 0) begin
            n_fail++;
            $display("FAIL str_counts: memwr %0d write %0d want 1 0", cnt_memwr, cnt_write);
        end
    endtask

    task automatic test_cmp();
        start_instr("cmp", 3'b101, 2'b01);
        exp_q.push_back(T_GETA);
        exp_q.push_back(T_GETB);
        exp_q.push_back(T_ALUC);
        drain();
        n_tests++;
        if (cnt_loads !== 1 || cnt_loadc !== 0 || cnt_write !== 0) begin
            n_fail++;
            $display("FAIL cmp_counts: loads %0d loadc %0d write %0d want 1 0 0",
                     cnt_loads, cnt_loadc, cnt_write);
        end
    endtask

    task automatic test_alu_ops();
        start_instr("mov_reg", 3'b110, 2'b00);
        exp_q.push_back(T_GETB);
        exp_q.push_back(T_ALUA);
        exp_q.push_back(T_WRD);
        drain();
        start_instr("mvn", 3'b101, 2'b11);
        exp_q.push_back(T_GETB);
        exp_q.push_back(T_ALUA);
        exp_q.push_back(T_WRD);
        drain();
        start_instr("add", 3'b101, 2'b00);
        exp_q.push_back(T_GETA);
        exp_q.push_back(T_GETB);
        exp_q.push_back(T_ALU);
        exp_q.push_back(T_WRD);
        drain();
        start_instr("and", 3'b101, 2'b10);
        exp_q.push_back(T_GETA);
        exp_q.push_back(T_GETB);
        exp_q.push_back(T_ALU);
        exp_q.push_back(T_WRD);
        drain();
    endtask

    task automatic test_reset_mid_ldr();
        start_instr("reset_mid_ldr", 3'b011, 2'b00);
        exp_q.push_back(T_GETA);
        exp_q.push_back(T_ACALC);
        exp_q.push_back(T_LADDR);
        exp_q.push_back(T_RD1);
        drain();
        reset = 1'b1;
        exp_q.push_back(T_RST);
        drain();
        n_tests++;
        if (cnt_write !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_ldr_write: got %0d write pulses want 0", cnt_write);
        end
    endtask

    task automatic test_illegal();
        start_instr("illegal", 3'b001, 2'b00);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        exp_q.push_back(T_TRAP);
        exp_q.push_back(T_TRAP);
        exp_q.push_back(T_TRAP);
`else
        exp_q.push_back(T_IF1);
        exp_q.push_back(T_IF2);
`endif
        drain();
        reset = 1'b1;
        exp_q.push_back(T_RST);
        drain();
    endtask

    task automatic test_halt();
        start_instr("halt", 3'b111, 2'b01);
        for (int i = 0; i < 50; i++) exp_q.push_back(T_HALT);
        drain();
        n_tests++;
        if (cnt_halt !== 50) begin
            n_fail++;
            $display("FAIL halt_hold: got %0d halted cycles want 50", cnt_halt);
        end
        tag   = "halt_reset";
        reset = 1'b1;
        exp_q.push_back(T_RST);
        drain();
        tag   = "halt_release";
        reset = 1'b0;
        exp_q.push_back(T_IF1);
        drain();
    endtask

    initial begin
        test_reset();
        test_mov_imm();
        test_ldr();
        test_str();
        test_cmp();
        test_alu_ops();
        test_reset_mid_ldr();
        test_illegal();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_ctrl_fsm.md
CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

Interface
REQ-001 SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have `opcode`, input, 3 bits, and `op`, input, 2 bits: both taken from the instruction register.
REQ-004 SHALL have these 1-bit outputs: `load_ir`, `load_pc`, `reset_pc`, `addr_sel` (1 = PC, 0 = data address), `load_addr`.
REQ-005 SHALL have `mem_cmd`, output, 2 bits: NONE=00, READ=01, WRITE=10.
REQ-006 SHALL have `nsel`, output, 3 bits, one-hot: [0]=Rm, [1]=Rd, [2]=Rn; 000 when no register is addressed.
REQ-007 SHALL have `vsel`, output, 2 bits: 0=C, 1=PC, 2=sximm8, 3=mdata.
REQ-008 SHALL have these 1-bit outputs: `write`, `loada`, `loadb`, `loadc`, `loads`, `asel`, `bsel`.
REQ-009 SHALL have `halted`, output, 1 bit, and `illegal`, output, 1 bit.

Function
REQ-010 SHALL be a Moore FSM: every output is decoded from the current state only; any output not listed for a state is 0.
REQ-011 SHALL give every state a one-cycle duration.
REQ-012 SHALL use this fetch sequence:
- RST (reset_pc=1, load_pc=1) -> IF1
- IF1 (addr_sel=1, mem_cmd=READ) -> IF2
- IF2 (addr_sel=1, mem_cmd=READ, load_ir=1) -> UPDATE_PC
- UPDATE_PC (load_pc=1) -> DECODE
REQ-013 SHALL branch from DECODE on {opcode,op}:
- 110_10 -> WRITE_IMM
- 110_00 -> GET_B
- 101_00, 101_01, 101_10 -> GET_A
- 101_11 -> GET_B
- 011_00 -> GET_A (LDR)
- 100_00 -> GET_A (STR)
- 111_xx -> HALT
REQ-014 SHALL define these register-operation states:
- WRITE_IMM: nsel=Rn, vsel=2, write=1 -> IF1.
- GET_A: nsel=Rn, loada=1 -> GET_B for ALU ops, -> ADDR_CALC for LDR/STR.
- GET_B: nsel=Rm, loadb=1 -> ALU.
REQ-015 SHALL define the ALU state as loadc=1 with asel=1 for MOV-register and MVN, then -> WRITE_RD.
- Exception: for CMP (101_01), ALU SHALL assert loads=1 with loadc=0 and go -> IF1.
REQ-016 SHALL define WRITE_RD as nsel=Rd, vsel=0, write=1 -> IF1.
REQ-017 SHALL use this LDR/STR address path:
- ADDR_CALC (bsel=1, loadc=1) -> LOAD_ADDR
- LOAD_ADDR (load_addr=1) -> MEM_RD1 for LDR, -> GET_D for STR
REQ-018 SHALL complete LDR as:
- MEM_RD1 (addr_sel=0, mem_cmd=READ) -> MEM_RD2
- MEM_RD2 (addr_sel=0, mem_cmd=READ, nsel=Rd, vsel=3, write=1) -> IF1
REQ-019 SHALL complete STR as:
- GET_D (nsel=Rd, loadb=1) -> PASS_D
- PASS_D (asel=1, loadc=1) -> MEM_WR
- MEM_WR (addr_sel=0, mem_cmd=WRITE) -> IF1
REQ-020 SHALL make HALT assert halted=1 with mem_cmd=NONE and self-loop; only reset exits HALT.
REQ-021 SHALL take these instruction lengths, counted IF1 to IF1: MOV-imm 5, CMP 7, MOV-reg/MVN 7, ADD/AND 8, LDR 9, STR 10 cycles.

Reset
REQ-022 SHALL load state RST on any rising edge with reset=1, from any state, including mid-instruction and HALT; reset overrides the transition table.
REQ-023 SHALL hold these values while in RST: reset_pc=1, load_pc=1, mem_cmd=NONE, write=0, halted=0, illegal=0.
REQ-024 SHALL leave RST for IF1 on the first edge with reset=0.

Configuration
REQ-025 SHALL, when CPU_CTRL_ILLEGAL_TRAP_EN is defined, route any {opcode,op} not listed in REQ-013 from DECODE to HALT with illegal=1; illegal stays 1 until reset.
REQ-026 SHALL, when CPU_CTRL_ILLEGAL_TRAP_EN is undefined, route any unlisted {opcode,op} from DECODE to IF1 (NOP), with illegal tied to 0.

Structure
REQ-027 SHALL take these definitions from shared package cpu_pkg:
- state enum
- mem_cmd encodings (MEM_NONE/MEM_READ/MEM_WRITE)
- vsel encodings
- nsel one-hot constants
- opcode/op constants
REQ-028 SHALL place the state register and next-state logic in cpu_ctrl_fsm; output decode SHALL be sub-module cpu_ctrl_outdec (combinational, state in, control bundle out).

Verification
REQ-029 SHALL cover: reset 2 cycles, release, opcode=110 op=10 -> IF1, IF2, UPDATE_PC, DECODE on edges 1-4; edge 5 WRITE_IMM with write=1, nsel=100, vsel=2; edge 6 IF1.
REQ-030 SHALL cover: LDR (011_00) -> mem_cmd=READ with addr_sel=0 in MEM_RD1 and MEM_RD2; write=1, vsel=3, nsel=010 in MEM_RD2; IF1 again 9 cycles after previous IF1.
REQ-031 SHALL cover: STR (100_00) -> exactly one cycle with mem_cmd=WRITE, addr_sel=0, 10 cycles IF1 to IF1; write=0 throughout.
REQ-032 SHALL cover: CMP (101_01) -> loads=1 for one cycle, loadc=0 and write=0 for the whole instruction.
REQ-033 SHALL cover: HALT (111) -> halted=1 held for 50 cycles with mem_cmd=NONE; then reset=1 -> RST next edge with halted=0, reset_pc=1.
REQ-034 SHALL cover: reset=1 asserted in MEM_RD1 -> RST next edge, no write pulse; opcode 001 -> HALT with illegal=1 when CPU_CTRL_ILLEGAL_TRAP_EN is defined, else IF1 with illegal=0.
